// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two 2-deep writeback queues (ALU, load) round-robin merged onto one register-file write port.
module regfile_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int COUNT = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             a_valid,
  input  logic [COUNT-1:0] a_index,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             m_valid,
  input  logic [COUNT-1:0] m_index,
  input  logic [WIDTH-1:0] m_data,
  output logic             m_ready,
  input  logic [COUNT-1:0] query_index,
  output logic             query_hit,
  output logic             regWrite,
  output logic [COUNT-1:0] writeIndex,
  output logic [WIDTH-1:0] writeData,
  output logic             idle
);
  typedef struct packed {
    logic [COUNT-1:0] idx;
    logic [WIDTH-1:0] dat;
  } ent_t;
  ent_t             ent_q [2][2];
  ent_t             ent_d [2][2];
  ent_t             req [2];
  ent_t             head;
  logic [1:0]       cnt_q [2];
  logic [1:0]       cnt_d [2];
  logic [1:0]       slot;
  logic [1:0]       vld, rdy, push, grant;
  logic             ptr_q, ptr_d, reg_write_q, reg_write_d;
  logic [COUNT-1:0] widx_q, widx_d;
  logic [WIDTH-1:0] wdat_q, wdat_d;
  always_comb begin
    req[0] = {a_index, a_data};
    req[1] = {m_index, m_data};
    vld = {m_valid, a_valid};
    grant[0] = (cnt_q[0] != 2'd0) && ((cnt_q[1] == 2'd0) || !ptr_q);
    grant[1] = (cnt_q[1] != 2'd0) && !grant[0];
    query_hit = 1'b0;
    slot = 2'd0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = RST && (cnt_q[i] != 2'd2);
      push[i] = vld[i] && rdy[i];
      cnt_d[i] = cnt_q[i] + {1'b0, push[i]} - {1'b0, grant[i]};
      slot = cnt_q[i] - {1'b0, grant[i]};
      ent_d[i][0] = grant[i] ? ent_q[i][1] : ent_q[i][0];
      ent_d[i][1] = ent_q[i][1];
      if (push[i] && slot == 2'd0) ent_d[i][0] = req[i];
      if (push[i] && slot != 2'd0) ent_d[i][1] = req[i];
      // only occupied slots count; the entry already on writeIndex has left its queue
      if (query_index != '0 && ((cnt_q[i] != 2'd0 && ent_q[i][0].idx == query_index) ||
                                (cnt_q[i] == 2'd2 && ent_q[i][1].idx == query_index)))
        query_hit = 1'b1;
    end
    head = grant[1] ? ent_q[1][0] : ent_q[0][0];
    ptr_d = grant[0] ? 1'b1 : (grant[1] ? 1'b0 : ptr_q);
    reg_write_d = (|grant) && (head.idx != '0);
    widx_d = reg_write_d ? head.idx : widx_q;
    wdat_d = reg_write_d ? head.dat : wdat_q;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= 2'd0;
        ent_q[i][0] <= '0;
        ent_q[i][1] <= '0;
      end
      ptr_q <= 1'b0;
      reg_write_q <= 1'b0;
      widx_q <= '0;
      wdat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
      ptr_q <= ptr_d;
      reg_write_q <= reg_write_d;
      widx_q <= widx_d;
      wdat_q <= wdat_d;
    end
  end
  assign a_ready = rdy[0];
  assign m_ready = rdy[1];
  assign regWrite = reg_write_q;
  assign writeIndex = widx_q;
  assign writeData = wdat_q;
  assign idle = (cnt_q[0] == 2'd0) && (cnt_q[1] == 2'd0) && !reg_write_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: queue-level reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;
  logic        CLK = 1'b0, RST = 1'b0, a_valid = 1'b0, m_valid = 1'b0;
  logic [4:0]  a_index = '0, m_index = '0, query_index = '0;
  logic [31:0] a_data = '0, m_data = '0;
  logic        a_ready, m_ready, query_hit, regWrite, idle;
  logic [4:0]  writeIndex;
  logic [31:0] writeData;

  regfile_wb_arbiter dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_index(a_index), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_index(m_index), .m_data(m_data), .m_ready(m_ready),
    .query_index(query_index), .query_hit(query_hit),
    .regWrite(regWrite), .writeIndex(writeIndex), .writeData(writeData), .idle(idle)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] dat;
  } ent_t;
  ent_t        aq[$], mq[$];
  logic        ptr = 1'b0, exp_wr = 1'b0, m_hit;
  logic [4:0]  exp_idx = '0;
  logic [31:0] exp_dat = '0;
  logic [4:0]  dlog[$];
  int          errors = 0, checks = 0;

  function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endfunction

  task automatic model_reset();
    aq.delete();
    mq.delete();
    ptr = 1'b0;
    exp_wr = 1'b0;
    exp_idx = '0;
    exp_dat = '0;
  endtask

  // one rising edge of the reference: choose a winner, retire its head, append accepted requests
  task automatic model_edge();
    ent_t h;
    logic ga, gm, pa, pm;
    pa = a_valid && aq.size() < 2;
    pm = m_valid && mq.size() < 2;
    ga = aq.size() != 0 && (mq.size() == 0 || !ptr);
    gm = !ga && mq.size() != 0;
    h = '{5'd0, 32'd0};
    if (ga) begin h = aq.pop_front(); ptr = 1'b1; end
    else if (gm) begin h = mq.pop_front(); ptr = 1'b0; end
    exp_wr = (ga || gm) && h.idx != 0;
    if (exp_wr) begin exp_idx = h.idx; exp_dat = h.dat; end
    if (pa) aq.push_back('{a_index, a_data});
    if (pm) mq.push_back('{m_index, m_data});
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_edge();
    @(negedge CLK);
    #2;
  endtask

  task automatic expect_wr(string n, logic we, logic [4:0] idx, logic [31:0] dat);
    chk({n, "_we"}, regWrite, we);
    if (we) begin
      chk({n, "_idx"}, writeIndex, idx);
      chk({n, "_dat"}, writeData, dat);
    end
  endtask

  task automatic hit_probe(string n, logic exp7);
    chk({n, "_q7"}, query_hit, exp7);
    query_index = 5'd8;
    #1;
    chk({n, "_q8"}, query_hit, 1'b0);
    query_index = 5'd7;
    #1;
  endtask

  task automatic drain(string n);
    for (int c = 0; c < 20 && !idle; c++) tick();
    chk({n, "_drain"}, idle, 1'b1);
  endtask

  always @(negedge CLK) begin
    m_hit = 1'b0;
    foreach (aq[i]) if (query_index != 0 && aq[i].idx == query_index) m_hit = 1'b1;
    foreach (mq[i]) if (query_index != 0 && mq[i].idx == query_index) m_hit = 1'b1;
    chk("a_ready", a_ready, RST && aq.size() < 2);
    chk("m_ready", m_ready, RST && mq.size() < 2);
    chk("regWrite", regWrite, exp_wr);
    chk("writeIndex", writeIndex, exp_idx);
    chk("writeData", writeData, exp_dat);
    chk("query_hit", query_hit, m_hit);
    chk("idle", idle, aq.size() == 0 && mq.size() == 0 && !exp_wr);
    if (regWrite) dlog.push_back(writeIndex);
  end

  initial begin
    int base, ai, mi;
    logic seen_full;
    logic [4:0] bp_exp [6];
    bp_exp = '{5'd20, 5'd10, 5'd21, 5'd11, 5'd22, 5'd12};

    repeat (2) @(negedge CLK);
    #2;
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_idle", idle, 1'b1);
    RST = 1'b1;
    tick();
    chk("post_rst_a_ready", a_ready, 1'b1);

    // single ALU write
    base = dlog.size();
    a_valid = 1'b1; a_index = 5'd3; a_data = 32'h0000_00AA;
    tick();
    a_valid = 1'b0;
    expect_wr("alu_k", 1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("alu_k1", 1'b1, 5'd3, 32'h0000_00AA);
    tick();
    expect_wr("alu_k2", 1'b0, 5'd0, 32'd0);
    chk("alu_hold_idx", writeIndex, 5'd3);
    chk("alu_count", dlog.size() - base, 1);

    // back-pressure with both requesters streaming
    base = dlog.size();
    ai = 0; mi = 0; seen_full = 1'b0;
    for (int c = 0; c < 40 && (ai < 3 || mi < 3); c++) begin
      logic acc_a, acc_m;
      a_valid = ai < 3; a_index = 5'(10 + ai); a_data = 32'h100 + ai;
      m_valid = mi < 3; m_index = 5'(20 + mi); m_data = 32'h200 + mi;
      if (a_valid && !a_ready) seen_full = 1'b1;
      acc_a = a_valid && a_ready;
      acc_m = m_valid && m_ready;
      tick();
      if (acc_a) ai++;
      if (acc_m) mi++;
    end
    a_valid = 1'b0; m_valid = 1'b0;
    chk("bp_accepted", ai * 10 + mi, 33);
    chk("bp_a_backpressure", seen_full, 1'b1);
    drain("bp");
    chk("bp_count", dlog.size() - base, 6);
    for (int i = 0; i < 6; i++)
      chk("bp_order", (base + i < dlog.size()) ? 32'(dlog[base + i]) : 32'hFFFF, 32'(bp_exp[i]));

    // r0 discard
    base = dlog.size();
    m_valid = 1'b1; m_index = 5'd0; m_data = 32'hDEAD_BEEF; query_index = 5'd0;
    tick();
    m_valid = 1'b0;
    chk("r0_hit_queued", query_hit, 1'b0);
    tick();
    expect_wr("r0_pop", 1'b0, 5'd0, 32'd0);
    chk("r0_idle", idle, 1'b1);
    chk("r0_count", dlog.size() - base, 0);

    // contention: alternate 1,4,2,5
    a_valid = 1'b1; a_index = 5'd1; a_data = 32'h11;
    m_valid = 1'b1; m_index = 5'd4; m_data = 32'h44;
    tick();
    expect_wr("ct_e1", 1'b0, 5'd0, 32'd0);
    a_index = 5'd2; a_data = 32'h22;
    m_index = 5'd5; m_data = 32'h55;
    tick();
    a_valid = 1'b0; m_valid = 1'b0;
    expect_wr("ct_w1", 1'b1, 5'd1, 32'h11);
    tick();
    expect_wr("ct_w2", 1'b1, 5'd4, 32'h44);
    tick();
    expect_wr("ct_w3", 1'b1, 5'd2, 32'h22);
    tick();
    expect_wr("ct_w4", 1'b1, 5'd5, 32'h55);
    tick();
    expect_wr("ct_end", 1'b0, 5'd0, 32'd0);
    chk("ct_idle", idle, 1'b1);

    // hazard query: load idx 7 waits behind ALU idx 9
    a_valid = 1'b1; a_index = 5'd9; a_data = 32'h99;
    m_valid = 1'b1; m_index = 5'd7; m_data = 32'h77;
    query_index = 5'd7;
    tick();
    a_valid = 1'b0; m_valid = 1'b0;
    hit_probe("hz_queued", 1'b1);
    tick();
    expect_wr("hz_w9", 1'b1, 5'd9, 32'h99);
    hit_probe("hz_waiting", 1'b1);
    tick();
    expect_wr("hz_w7", 1'b1, 5'd7, 32'h77);
    hit_probe("hz_popped", 1'b0);
    drain("hz");

    // reset in the middle of traffic
    a_valid = 1'b1; a_index = 5'd13; a_data = 32'h13;
    m_valid = 1'b1; m_index = 5'd23; m_data = 32'h23;
    query_index = 5'd13;
    repeat (3) tick();
    chk("mr_pre_we", regWrite, 1'b1);
    chk("mr_pre_hit", query_hit, 1'b1);
    RST = 1'b0;
    model_reset();
    a_valid = 1'b0; m_valid = 1'b0;
    #1;
    chk("mr_we", regWrite, 1'b0);
    chk("mr_idx", writeIndex, 5'd0);
    chk("mr_dat", writeData, 32'd0);
    chk("mr_a_ready", a_ready, 1'b0);
    chk("mr_m_ready", m_ready, 1'b0);
    chk("mr_hit", query_hit, 1'b0);
    chk("mr_idle", idle, 1'b1);
    repeat (2) tick();
    RST = 1'b1;
    base = dlog.size();
    repeat (3) tick();
    chk("mr_no_stale", dlog.size() - base, 0);
    chk("mr_a_ready_after", a_ready, 1'b1);
    a_valid = 1'b1; a_index = 5'd6; a_data = 32'h600D;
    tick();
    a_valid = 1'b0;
    expect_wr("mr_new_k", 1'b0, 5'd0, 32'd0);
    tick();
    expect_wr("mr_new_k1", 1'b1, 5'd6, 32'h600D);
    drain("mr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
